// File: rtl/gf3557_pkg.sv
// Shared definitions for the GF(3557) arithmetic blocks.
//   Q3557 / W3557  : prime modulus and its residue width
//   residue_t      : one reduced residue
//   frame_state_e  : position of the accumulator within a frame
//   modadd_3557    : (a + b) mod 3557 for a, b < 3557
package gf3557_pkg;

  localparam int unsigned W3557 = 12;
  localparam int unsigned Q3557 = 3557;

  typedef logic [W3557-1:0] residue_t;

  typedef enum logic {
    FRAME_FILL = 1'b0,  // more beats to come in this frame
    FRAME_LAST = 1'b1   // next accepted beat closes the frame
  } frame_state_e;

  // Both operands are below Q, so their sum is below 2Q and one
  // conditional subtract fully reduces it.
  function automatic residue_t modadd_3557(residue_t a, residue_t b);
    logic [W3557:0] s;
    // NOTE: blocking assignments inside functions and always_comb; they
    // describe combinational evaluation order, not registers.
    s = {1'b0, a} + {1'b0, b};
    if (s >= (W3557 + 1)'(Q3557)) begin
      s = s - (W3557 + 1)'(Q3557);
    end
    return s[W3557-1:0];
  endfunction

endpackage

// File: rtl/mod_add_3557.sv
// Combinational modular adder: sum = (a + b) mod Q, with a, b < Q.
// Shared with the butterfly datapath.
//   a, b : W-bit operands, each already reduced
//   sum  : W-bit reduced sum
module mod_add_3557
  import gf3557_pkg::*;
#(
  parameter int Q = Q3557,
  parameter int W = W3557
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  if (Q == Q3557 && W == W3557) begin : g_fixed
    // The shared package function keeps every 3557 datapath bit-identical.
    assign sum = modadd_3557(a, b);
  end else begin : g_generic
    localparam logic [W:0] QW = (W + 1)'(Q);
    logic [W:0] s;
    always_comb begin
      s = {1'b0, a} + {1'b0, b};
      if (s >= QW) begin
        s = s - QW;
      end
    end
    assign sum = s[W-1:0];
  end

endmodule

// File: rtl/mod_accum_3557.sv
// Streaming modular accumulator: sums LEN residues per frame mod Q and
// presents one reduced result per frame.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input beat handshake, in_data is a residue
//   out_valid/out_ready  : result handshake, out_data is frame sum mod Q
//   err                  : sticky, some accepted in_data was >= Q
module mod_accum_3557
  import gf3557_pkg::*;
#(
  parameter int Q     = Q3557,
  parameter int W     = W3557,
  parameter int LEN   = 16,
  parameter int CNT_W = (LEN > 1) ? $clog2(LEN) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         err
);

  localparam logic [W:0]       QW       = (W + 1)'(Q);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic [W-1:0]     acc;
  logic [CNT_W-1:0] cnt;
  frame_state_e     state;
  logic             in_range;
  logic [W-1:0]     x;
  logic [W-1:0]     sum;
  logic             accept;
  logic             final_accept;

  // Frame position is fully encoded by cnt; the held-result condition
  // lives in out_valid and is orthogonal to it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state = FRAME_FILL;
    if (cnt == LAST_CNT) begin
      state = FRAME_LAST;
    end
  end

  // Out-of-range residues contribute nothing and raise err.
  always_comb begin
    in_range = ({1'b0, in_data} < QW);
    x        = in_range ? in_data : '0;
  end

  mod_add_3557 #(
    .Q (Q),
    .W (W)
  ) u_add (
    .a   (acc),
    .b   (x),
    .sum (sum)
  );

  // Only the closing beat can stall, and only while an untaken result
  // would otherwise be overwritten; a result being taken this cycle
  // frees the register for the new one.
  assign in_ready     = ~((state == FRAME_LAST) & out_valid & ~out_ready);
  assign accept       = in_valid & in_ready;
  assign final_accept = accept & (state == FRAME_LAST);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= final_accept | (out_valid & ~out_ready);
      if (accept) begin
        if (!in_range) begin
          err <= 1'b1;
        end
        if (state == FRAME_LAST) begin
          out_data <= sum;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mod_accum_3557.sv
`timescale 1ns/1ps
module tb_mod_accum_3557;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic        err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #(PERIOD / 2) clk = ~clk;

  mod_accum_3557 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every completed output handshake must match the oldest
  // expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none", out_data);
      end else begin
        check("frame_result", int'(out_data), exp_q.pop_front());
      end
    end
  end

  // Presents one beat and returns just after the edge that accepted it.
  task automatic send(input int d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = 12'(d);
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rep(input int d, input int count);
    for (int i = 0; i < count; i++) send(d);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin
    time t0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // -16 mod 3557
    exp_q.push_back(3541);
    send_rep(3556, 16);
    drain();
    check("t1_err", int'(err), 0);

    // Two frames back to back, no idle cycles
    exp_q.push_back(120);
    exp_q.push_back(16);
    t0 = $time;
    for (int i = 0; i < 16; i++) send(i);
    send_rep(1, 16);
    check("t2_cycles", int'(($time - t0) / PERIOD), 32);
    drain();

    // 3000 + 557 wraps exactly to 0
    exp_q.push_back(0);
    send(3000);
    send(557);
    send_rep(0, 14);
    drain();

    // Backpressure: next frame fills, its last beat stalls
    out_ready = 1'b0;
    exp_q.push_back(32);
    exp_q.push_back(48);
    send_rep(2, 16);
    t0 = $time;
    send_rep(3, 15);
    check("t4_fill_cycles", int'(($time - t0) / PERIOD), 15);
    in_valid = 1'b1;
    in_data  = 12'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_hold_in_ready", int'(in_ready), 0);
      check("t4_hold_out_valid", int'(out_valid), 1);
      check("t4_hold_out_data", int'(out_data), 32);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("t4_new_out_valid", int'(out_valid), 1);
    check("t4_new_out_data", int'(out_data), 48);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Out-of-range beat counts as 0 and sets sticky err
    exp_q.push_back(15);
    send(4000);
    send_rep(1, 15);
    drain();
    check("t5_err_set", int'(err), 1);
    exp_q.push_back(16);
    send_rep(1, 16);
    drain();
    check("t5_err_sticky", int'(err), 1);

    // Reset mid-frame discards the partial sum
    send_rep(100, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    rst = 1'b0;
    exp_q.push_back(16);
    send_rep(1, 16);
    drain();
    repeat (20) @(posedge clk);
    #1;
    check("final_out_valid", int'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
